param_cpu: RTL and testbench

Parametrised successor to the 4-bit accumulator CPU. Executes one externally supplied instruction (opcode, address, operand) at a time against a DW-bit, 2^AW-entry register memory and an SD-deep hardware stack. Adds a valid/ready instruction handshake, correct write-back and flag semantics, stack overflow/underflow detection and a sticky halt. Sits between the instruction source (test sequencer or future fetch unit) and any consumer of `myoutput`.

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/cpu_alu.sv | 34 +++
 rtl/param_cpu.sv | 200 ++++++++++++++++++++
 tb/tb_param_cpu.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the parametrised accumulator CPU: opcodes,
// controller states and flag bit positions.
package cpu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_XCHG = 4'h2;
  localparam logic [3:0] OP_MOV  = 4'h3;
  localparam logic [3:0] OP_SHR  = 4'h4;
  localparam logic [3:0] OP_IN   = 4'h5;
  localparam logic [3:0] OP_OUT  = 4'h6;
  localparam logic [3:0] OP_AND  = 4'h7;
  localparam logic [3:0] OP_CLRF = 4'h8;
  localparam logic [3:0] OP_OR   = 4'h9;
  localparam logic [3:0] OP_XOR  = 4'hA;
  localparam logic [3:0] OP_PUSH = 4'hB;
  localparam logic [3:0] OP_POP  = 4'hC;
  localparam logic [3:0] OP_SHL  = 4'hD;
  localparam logic [3:0] OP_NOT  = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_XCHG2,
    ST_HALT
  } state_t;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_S = 2;

endpackage

// File: rtl/cpu_alu.sv
// Combinational arithmetic/logic unit; ops it does not know pass m through.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] m,
  input  logic [DW-1:0] operand,
  input  logic [3:0]    opcode,
  output logic [DW-1:0] r,
  output logic          carry,
  output logic          sign
);

  always_comb begin
    r     = m;
    carry = 1'b0;
    case (opcode)
      OP_ADD:  {carry, r} = {1'b0, m} + {1'b0, operand};
      OP_SUB:  begin r = m - operand; carry = (m < operand); end
      OP_SHR:  begin r = {1'b0, m[DW-1:1]}; carry = m[0]; end
      OP_SHL:  begin r = {m[DW-2:0], 1'b0}; carry = m[DW-1]; end
      OP_AND:  r = m & operand;
      OP_OR:   r = m | operand;
      OP_XOR:  r = m ^ operand;
      OP_NOT:  r = ~m;
      OP_IN:   r = operand;
      default: ;
    endcase
  end

  assign sign = r[DW-1];

endmodule

// File: rtl/param_cpu.sv
// Accumulator CPU executing one handshaked instruction at a time against a
// register memory and a descending hardware stack, with sticky halt.
module param_cpu
  import cpu_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 4,
  parameter int SD = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [3:0]    opcode,
  input  logic [AW-1:0] address,
  input  logic [DW-1:0] myinput,
  output logic [DW-1:0] myoutput,
  output logic          out_valid,
  output logic          hlt,
  output logic          s_flag,
  output logic          z_flag,
  output logic          c_flag,
  output logic          stk_err
);

  localparam int DEPTH = 2 ** AW;
  localparam int SIW   = $clog2(SD);
  localparam int SPW   = SIW + 1;

  state_t state_reg, state_next;

  logic [3:0]    op_reg;
  logic [AW-1:0] addr_reg;
  logic [DW-1:0] operand_reg;
  logic [DW-1:0] hold_reg;
  logic [DW-1:0] mem_reg [DEPTH];
  logic [DW-1:0] stk_reg [SD];
  logic [SPW-1:0] sp_reg;
  logic [2:0]    flags_reg;
  logic [DW-1:0] out_reg;
  logic          out_valid_reg, hlt_reg, stk_err_reg;

  logic          accept;
  logic [AW-1:0] addr1;
  logic [DW-1:0] m, m1;
  logic [SPW-1:0] sp_dec;
  logic [SIW-1:0] push_idx, pop_idx;
  logic          sp_full, sp_empty;
  logic [DW-1:0] alu_r;
  logic          alu_c, alu_s;

  logic [DW-1:0] res;
  logic          wr_en, res_en, c_en, c_val, s_en, s_val;
  logic          push_en, pop_en, err_set, clr_en;

  assign instr_ready = (state_reg == ST_IDLE);
  assign accept      = instr_valid && instr_ready;
  assign addr1       = addr_reg + AW'(1);
  assign m           = mem_reg[addr_reg];
  assign m1          = mem_reg[addr1];
  // sp counts down from SD; sp==0 means every slot is occupied
  assign sp_dec      = sp_reg - SPW'(1);
  assign push_idx    = sp_dec[SIW-1:0];
  assign pop_idx     = sp_reg[SIW-1:0];
  assign sp_full     = (sp_reg == '0);
  assign sp_empty    = (sp_reg == SPW'(SD));

  cpu_alu #(.DW(DW)) u_alu (
    .m       (m),
    .operand (operand_reg),
    .opcode  (op_reg),
    .r       (alu_r),
    .carry   (alu_c),
    .sign    (alu_s)
  );

  always_comb begin
    res     = alu_r;
    wr_en   = 1'b0;
    res_en  = 1'b0;
    c_en    = 1'b0;
    c_val   = alu_c;
    s_en    = 1'b0;
    s_val   = 1'b0;
    push_en = 1'b0;
    pop_en  = 1'b0;
    err_set = 1'b0;
    clr_en  = 1'b0;
    case (op_reg)
      OP_ADD, OP_SHR, OP_SHL: begin wr_en = 1'b1; res_en = 1'b1; c_en = 1'b1; end
      OP_SUB: begin
        wr_en = 1'b1; res_en = 1'b1; c_en = 1'b1; s_en = 1'b1; s_val = alu_s;
      end
      OP_AND, OP_OR, OP_XOR: begin
        wr_en = 1'b1; res_en = 1'b1; c_en = 1'b1; c_val = 1'b0; s_en = 1'b1;
      end
      OP_NOT:  begin wr_en = 1'b1; res_en = 1'b1; s_en = 1'b1; end
      OP_IN:   begin wr_en = 1'b1; res_en = 1'b1; end
      OP_OUT:  begin res = m; res_en = 1'b1; end
      OP_MOV:  begin res = mem_reg[0]; wr_en = 1'b1; res_en = 1'b1; end
      OP_XCHG: begin res = m1; wr_en = 1'b1; res_en = 1'b1; end
      OP_CLRF: begin res = m; clr_en = 1'b1; end
      OP_PUSH: begin
        res = m;
        if (sp_full) err_set = 1'b1;
        else begin push_en = 1'b1; res_en = 1'b1; end
      end
      OP_POP: begin
        res = stk_reg[pop_idx];
        if (sp_empty) err_set = 1'b1;
        else begin pop_en = 1'b1; wr_en = 1'b1; res_en = 1'b1; end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (accept) state_next = (opcode == OP_HLT) ? ST_HALT : ST_EXEC;
      ST_EXEC:  state_next = (op_reg == OP_XCHG) ? ST_XCHG2 : ST_IDLE;
      ST_XCHG2: state_next = ST_IDLE;
      ST_HALT:  state_next = ST_HALT;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= DW'(i);
      for (int i = 0; i < SD; i++) stk_reg[i] <= '0;
      sp_reg        <= SPW'(SD);
      op_reg        <= '0;
      addr_reg      <= '0;
      operand_reg   <= '0;
      hold_reg      <= '0;
      flags_reg     <= '0;
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
      hlt_reg       <= 1'b0;
      stk_err_reg   <= 1'b0;
    end else begin
      out_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            op_reg      <= opcode;
            addr_reg    <= address;
            operand_reg <= myinput;
            if (opcode == OP_HLT) begin
              hlt_reg       <= 1'b1;
              out_valid_reg <= 1'b1;
            end
          end
        end
        ST_EXEC: begin
          hold_reg <= m;
          if (wr_en) mem_reg[addr_reg] <= res;
          if (res_en) begin
            out_reg           <= res;
            flags_reg[FLAG_Z] <= (res == '0);
          end
          if (c_en) flags_reg[FLAG_C] <= c_val;
          if (s_en) flags_reg[FLAG_S] <= s_val;
          if (push_en) begin
            stk_reg[push_idx] <= m;
            sp_reg            <= sp_dec;
          end
          if (pop_en) sp_reg <= sp_reg + SPW'(1);
          if (err_set) stk_err_reg <= 1'b1;
          if (clr_en) begin
            flags_reg   <= '0;
            stk_err_reg <= 1'b0;
            out_reg     <= res;
          end
          if (op_reg != OP_XCHG) out_valid_reg <= 1'b1;
        end
        ST_XCHG2: begin
          mem_reg[addr1] <= hold_reg;
          out_valid_reg  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign myoutput  = out_reg;
  assign out_valid = out_valid_reg;
  assign hlt       = hlt_reg;
  assign stk_err   = stk_err_reg;
  assign s_flag    = flags_reg[FLAG_S];
  assign z_flag    = flags_reg[FLAG_Z];
  assign c_flag    = flags_reg[FLAG_C];

endmodule

// File: tb/tb_param_cpu.sv
// Self-checking bench for param_cpu: directed scenarios plus randomized
// instruction streams compared against a queue-based reference model.
module tb_param_cpu;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int SD    = 16;
  localparam int DEPTH = 2 ** AW;
  localparam int MOD   = 2 ** DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [3:0]    opcode = '0;
  logic [AW-1:0] address = '0;
  logic [DW-1:0] myinput = '0;
  logic [DW-1:0] myoutput;
  logic          out_valid, hlt, s_flag, z_flag, c_flag, stk_err;

  int checks = 0;
  int errors = 0;

  int m_mem [DEPTH];
  int m_stk [$];
  int m_out;
  bit m_c, m_s, m_z, m_err;

  param_cpu #(.DW(DW), .AW(AW), .SD(SD)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .opcode      (opcode),
    .address     (address),
    .myinput     (myinput),
    .myoutput    (myoutput),
    .out_valid   (out_valid),
    .hlt         (hlt),
    .s_flag      (s_flag),
    .z_flag      (z_flag),
    .c_flag      (c_flag),
    .stk_err     (stk_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = i % MOD;
    m_stk.delete();
    m_out = 0; m_c = 0; m_s = 0; m_z = 0; m_err = 0;
  endfunction

  // Architectural effect of one instruction, from the ISA rules only.
  function automatic void model_exec(input int op, input int a, input int d);
    int m, a1, r;
    bit wr;
    m  = m_mem[a];
    a1 = (a + 1) % DEPTH;
    r  = m;
    wr = 1;
    case (op)
      0:  begin r = (m + d) % MOD; m_c = (m + d) >= MOD; end
      1:  begin r = (m - d + MOD) % MOD; m_c = (m < d); m_s = (r >= MOD / 2); end
      2:  begin r = m_mem[a1]; m_mem[a1] = m; end
      3:  r = m_mem[0];
      4:  begin r = m / 2; m_c = (m % 2) == 1; end
      5:  r = d;
      6:  wr = 0;
      7:  begin r = m & d; m_c = 0; m_s = 0; end
      8:  begin m_c = 0; m_s = 0; m_z = 0; m_err = 0; m_out = m; return; end
      9:  begin r = m | d; m_c = 0; m_s = 0; end
      10: begin r = m ^ d; m_c = 0; m_s = 0; end
      11: begin
        if (m_stk.size() == SD) begin m_err = 1; return; end
        m_stk.push_front(m);
        wr = 0;
      end
      12: begin
        if (m_stk.size() == 0) begin m_err = 1; return; end
        r = m_stk.pop_front();
      end
      13: begin r = (m * 2) % MOD; m_c = (m >= MOD / 2); end
      14: begin r = MOD - 1 - m; m_s = 0; end
      default: return;
    endcase
    if (wr) m_mem[a] = r;
    m_out = r;
    m_z   = (r == 0);
  endfunction

  task automatic do_reset();
    instr_valid = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  // Issue one instruction; lat counts cycles from the accept edge to out_valid.
  task automatic issue(input int op, input int a, input int d, output int lat, output logic rdy);
    int w;
    w = 0;
    while (instr_ready !== 1'b1 && w < 20) begin @(posedge clk); #1; w++; end
    if (instr_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL ready_timeout: instr_ready=%b required 1", instr_ready);
    end
    instr_valid = 1'b1;
    opcode  = 4'(op);
    address = AW'(a);
    myinput = DW'(d);
    @(posedge clk); #1;
    instr_valid = 1'($urandom_range(0, 1));
    opcode  = 4'($urandom);
    address = AW'($urandom);
    myinput = DW'($urandom);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 8) begin @(posedge clk); #1; lat++; end
    instr_valid = 1'b0;
    rdy = instr_ready;
    $display("instr op=%h a=%0d d=%h -> out=%h z=%b c=%b s=%b err=%b lat=%0d",
             op, a, d, myoutput, z_flag, c_flag, s_flag, stk_err, lat);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (myoutput !== '0) begin errors++; $display("FAIL reset_out: got %h want 00", myoutput); end
    checks++; if ({s_flag, z_flag, c_flag} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {s_flag, z_flag, c_flag}); end
    checks++; if (hlt !== 1'b0) begin errors++; $display("FAIL reset_hlt: got %b want 0", hlt); end
    checks++; if (stk_err !== 1'b0) begin errors++; $display("FAIL reset_stk_err: got %b want 0", stk_err); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", instr_ready); end
  endtask

  typedef struct {
    int op; int a; int d;
    int out; bit z; bit c; bit s; int lat;
  } dir_t;

  task automatic test_directed();
    dir_t tbl [8];
    int lat;
    logic rdy;
    tbl[0] = '{6, 5, 0, 8'h05, 0, 0, 0, 1};
    tbl[1] = '{6, 0, 0, 8'h00, 1, 0, 0, 1};
    tbl[2] = '{0, 15, 8'hF5, 8'h04, 0, 1, 0, 1};
    tbl[3] = '{6, 15, 0, 8'h04, 0, 1, 0, 1};
    tbl[4] = '{1, 2, 3, 8'hFF, 0, 1, 1, 1};
    tbl[5] = '{2, 15, 0, 8'h00, 1, 0, 0, 2};
    tbl[6] = '{6, 15, 0, 8'h00, 1, 0, 0, 1};
    tbl[7] = '{6, 0, 0, 8'h0F, 0, 0, 0, 1};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i == 5) do_reset();
      issue(tbl[i].op, tbl[i].a, tbl[i].d, lat, rdy);
      checks++; if (myoutput !== DW'(tbl[i].out)) begin errors++; $display("FAIL dir%0d_out: got %h want %h", i, myoutput, tbl[i].out); end
      checks++; if ({z_flag, c_flag, s_flag} !== {tbl[i].z, tbl[i].c, tbl[i].s}) begin errors++; $display("FAIL dir%0d_flags zcs: got %b want %b", i, {z_flag, c_flag, s_flag}, {tbl[i].z, tbl[i].c, tbl[i].s}); end
      checks++; if (lat !== tbl[i].lat) begin errors++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, tbl[i].lat); end
    end
  endtask

  task automatic test_stack();
    int lat, a;
    logic rdy;
    logic [DW-1:0] prev;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      a = $urandom_range(0, MOD - 1);
      issue(5, i, a, lat, rdy); model_exec(5, i, a);
    end
    for (int i = 0; i <= SD; i++) begin
      a = $urandom_range(0, DEPTH - 1);
      prev = myoutput;
      issue(11, a, 0, lat, rdy); model_exec(11, a, 0);
      checks++; if (myoutput !== DW'(m_out)) begin errors++; $display("FAIL push%0d_out: got %h want %h (prev %h)", i, myoutput, m_out[DW-1:0], prev); end
      checks++; if (stk_err !== m_err) begin errors++; $display("FAIL push%0d_stk_err: got %b want %b", i, stk_err, m_err); end
    end
    for (int i = 0; i <= SD; i++) begin
      a = (i == SD) ? 3 : $urandom_range(0, DEPTH - 1);
      issue(12, a, 0, lat, rdy); model_exec(12, a, 0);
      checks++; if (myoutput !== DW'(m_out)) begin errors++; $display("FAIL pop%0d_out: got %h want %h", i, myoutput, m_out[DW-1:0]); end
      checks++; if (stk_err !== m_err) begin errors++; $display("FAIL pop%0d_stk_err: got %b want %b", i, stk_err, m_err); end
    end
    issue(6, 3, 0, lat, rdy); model_exec(6, 3, 0);
    checks++; if (myoutput !== DW'(m_mem[3])) begin errors++; $display("FAIL underflow_mem: got %h want %h", myoutput, m_mem[3][DW-1:0]); end
    issue(8, 4, 0, lat, rdy); model_exec(8, 4, 0);
    checks++; if (stk_err !== 1'b0) begin errors++; $display("FAIL clrf_stk_err: got %b want 0", stk_err); end
    checks++; if ({z_flag, c_flag, s_flag} !== 3'b000) begin errors++; $display("FAIL clrf_flags: got %b want 000", {z_flag, c_flag, s_flag}); end
    checks++; if (myoutput !== DW'(m_out)) begin errors++; $display("FAIL clrf_out: got %h want %h", myoutput, m_out[DW-1:0]); end
  endtask

  task automatic test_random();
    int lat, op, a, d;
    logic rdy;
    do_reset();
    for (int n = 0; n < 300; n++) begin
      op = $urandom_range(0, 14);
      a  = $urandom_range(0, DEPTH - 1);
      d  = $urandom_range(0, MOD - 1);
      issue(op, a, d, lat, rdy); model_exec(op, a, d);
      checks++; if (myoutput !== DW'(m_out)) begin errors++; $display("FAIL rnd%0d_out op=%h: got %h want %h", n, op, myoutput, m_out[DW-1:0]); end
      checks++; if ({z_flag, c_flag, s_flag, stk_err} !== {m_z, m_c, m_s, m_err}) begin errors++; $display("FAIL rnd%0d_flags op=%h zcse: got %b want %b", n, op, {z_flag, c_flag, s_flag, stk_err}, {m_z, m_c, m_s, m_err}); end
      checks++; if (lat !== ((op == 2) ? 2 : 1)) begin errors++; $display("FAIL rnd%0d_latency op=%h: got %0d want %0d", n, op, lat, (op == 2) ? 2 : 1); end
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL rnd%0d_ready_after: got %b want 1", n, rdy); end
    end
    for (int i = 0; i < DEPTH; i++) begin
      issue(6, i, 0, lat, rdy); model_exec(6, i, 0);
      checks++; if (myoutput !== DW'(m_mem[i])) begin errors++; $display("FAIL sweep_mem%0d: got %h want %h", i, myoutput, m_mem[i][DW-1:0]); end
    end
  endtask

  task automatic test_halt();
    int lat;
    logic rdy;
    logic [DW-1:0] held;
    do_reset();
    issue(5, 7, 8'h55, lat, rdy); model_exec(5, 7, 8'h55);
    issue(15, 0, 0, lat, rdy);
    checks++; if (lat !== 0) begin errors++; $display("FAIL hlt_latency: got %0d want 0", lat); end
    checks++; if (hlt !== 1'b1) begin errors++; $display("FAIL hlt_set: got %b want 1", hlt); end
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL hlt_ready: got %b want 0", rdy); end
    held = myoutput;
    instr_valid = 1'b1; opcode = 4'h0; address = 4'd7; myinput = 8'h01;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0 || instr_ready !== 1'b0 || myoutput !== held) begin
        errors++; $display("FAIL halted_cycle%0d: out_valid=%b ready=%b out=%h want 0 0 %h", i, out_valid, instr_ready, myoutput, held);
      end
    end
    instr_valid = 1'b0;
    do_reset();
    checks++; if (hlt !== 1'b0) begin errors++; $display("FAIL hlt_cleared: got %b want 0", hlt); end
    issue(6, 7, 0, lat, rdy); model_exec(6, 7, 0);
    checks++; if (myoutput !== 8'h07) begin errors++; $display("FAIL mem_restored: got %h want 07", myoutput); end
  endtask

  task automatic test_reset_mid_xchg();
    int lat;
    logic rdy;
    bit seen;
    do_reset();
    instr_valid = 1'b1; opcode = 4'h2; address = 4'd3; myinput = '0;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    seen = 0;
    @(posedge clk); #1;
    seen |= out_valid;
    rst = 1'b0;
    @(posedge clk); #1;
    seen |= out_valid;
    rst = 1'b1;
    @(posedge clk); #1;
    seen |= out_valid;
    model_reset();
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL xchg_reset_out_valid: got 1 want 0"); end
    issue(6, 4, 0, lat, rdy); model_exec(6, 4, 0);
    checks++; if (myoutput !== 8'h04) begin errors++; $display("FAIL xchg_reset_mem_a1: got %h want 04", myoutput); end
    issue(6, 3, 0, lat, rdy); model_exec(6, 3, 0);
    checks++; if (myoutput !== 8'h03) begin errors++; $display("FAIL xchg_reset_mem_a: got %h want 03", myoutput); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stack();
    test_random();
    test_halt();
    test_reset_mid_xchg();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
